// File: rtl/dsi_hs_pkg.sv
// rtl/dsi_hs_pkg.sv - shared types and constants for the DSI HS lane sequencer
package dsi_hs_pkg;

  localparam int         HS_LANES  = 4;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {IDLE, PREP, ZERO, SYNC, DATA, TRAIL, EXIT} hs_state_t;

  // What a lane puts on its byte output in the current cycle
  typedef enum logic [2:0] {LM_OFF, LM_ZERO, LM_SYNC, LM_DATA, LM_TRAIL} lane_mode_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dsi_hs_lane_tail.sv
// rtl/dsi_hs_lane_tail.sv - per-lane done flag, trail byte and output byte mux
module dsi_hs_lane_tail
  import dsi_hs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  lane_mode_t mode,
  input  logic       clear,
  input  logic       force_done,
  input  logic       strb,
  input  logic [7:0] data_byte,
  output logic       done_nat,
  output logic [7:0] byte_q
);

  logic       done_q, done_d;
  logic [7:0] trail_q, trail_d;
  logic [7:0] byte_d;

  // done_nat excludes force_done so the watchdog can decide on it without a loop
  assign done_nat = done_q | ((mode == LM_DATA) & strb);

  always_comb begin
    done_d  = done_q;
    trail_d = trail_q;
    byte_d  = 8'h00;
    case (mode)
      LM_ZERO:  byte_d = 8'h00;
      LM_SYNC:  byte_d = SYNC_BYTE;
      LM_DATA: begin
        if (done_q) begin
          byte_d = trail_q;
        end else begin
          byte_d = data_byte;
          if (strb) begin
            done_d  = 1'b1;
            trail_d = {8{~data_byte[7]}};
          end else if (force_done) begin
            done_d  = 1'b1;
            trail_d = 8'h00;
          end
        end
      end
      LM_TRAIL: byte_d = trail_q;
      default:  byte_d = 8'h00;
    endcase
    if (clear) begin
      done_d  = 1'b0;
      trail_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      trail_q <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      done_q  <= done_d;
      trail_q <= trail_d;
      byte_q  <= byte_d;
    end
  end

endmodule

// File: rtl/dsi_hs_lanes_sequencer.sv
// rtl/dsi_hs_lanes_sequencer.sv - one 4-lane DSI HS burst per start pulse
// Optional payload watchdog enabled by HS_LANES_WATCHDOG_EN.
module dsi_hs_lanes_sequencer
  import dsi_hs_pkg::*;
#(
  parameter int T_PREP    = 4,
  parameter int T_ZERO    = 6,
  parameter int T_TRAIL   = 4,
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        repacker_enable,
  output logic        data_req,
  input  logic [31:0] data_in,
  input  logic [3:0]  last_strb,
  output logic [3:0]  hs_request,
  output logic [3:0]  hs_valid,
  output logic [31:0] hs_data,
  output logic        error
);

  localparam int CW = $clog2(max3(T_PREP, T_ZERO, T_TRAIL) + 1);

  hs_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          enable_q, enable_d;
  logic          req_q, req_d;
  logic [3:0]    hs_request_q, hs_request_d;
  logic [3:0]    hs_valid_q, hs_valid_d;

  lane_mode_t            mode;
  logic [HS_LANES-1:0]   done_nat;
  logic                  abort;
  logic                  all_done;

  assign all_done = (&done_nat) | abort;

`ifdef HS_LANES_WATCHDOG_EN
  localparam int WW = $clog2(MAX_WORDS + 1);

  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic          error_q, error_d;

  assign abort = (state_q == DATA) && (word_cnt_q == WW'(MAX_WORDS - 1)) && !(&done_nat);

  always_comb begin
    word_cnt_d = (state_q == DATA) ? word_cnt_q + WW'(1) : '0;
    error_d    = abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      error_q    <= error_d;
    end
  end

  assign error = error_q;
`else
  assign abort = 1'b0;
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = PREP;
        cnt_d   = CW'(T_PREP - 1);
      end
      PREP: if (cnt_q == '0) begin
        state_d = ZERO;
        cnt_d   = CW'(T_ZERO - 1);
      end
      ZERO:  if (cnt_q == '0) state_d = SYNC;
      SYNC:  state_d = DATA;
      DATA: if (all_done) begin
        state_d = TRAIL;
        cnt_d   = CW'(T_TRAIL - 1);
      end
      TRAIL: if (cnt_q == '0) state_d = EXIT;
      EXIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    hs_request_d = (state_q inside {PREP, ZERO, SYNC, DATA, TRAIL}) ? 4'hF : 4'h0;
    hs_valid_d   = (state_q inside {ZERO, SYNC, DATA, TRAIL}) ? 4'hF : 4'h0;
    enable_d     = (state_q inside {ZERO, SYNC, DATA, TRAIL});
    req_d        = (state_q == DATA) && !all_done;

    case (state_q)
      ZERO:    mode = LM_ZERO;
      SYNC:    mode = LM_SYNC;
      DATA:    mode = LM_DATA;
      TRAIL:   mode = LM_TRAIL;
      default: mode = LM_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      enable_q     <= 1'b0;
      req_q        <= 1'b0;
      hs_request_q <= 4'h0;
      hs_valid_q   <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      enable_q     <= enable_d;
      req_q        <= req_d;
      hs_request_q <= hs_request_d;
      hs_valid_q   <= hs_valid_d;
    end
  end

  for (genvar i = 0; i < HS_LANES; i++) begin : g_lane
    dsi_hs_lane_tail u_tail (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .clear      (state_q == IDLE),
      .force_done (abort),
      .strb       (last_strb[i]),
      .data_byte  (data_in[8*i +: 8]),
      .done_nat   (done_nat[i]),
      .byte_q     (hs_data[8*i +: 8])
    );
  end

  assign busy            = busy_q;
  assign repacker_enable = enable_q;
  assign data_req        = req_q;
  assign hs_request      = hs_request_q;
  assign hs_valid        = hs_valid_q;

endmodule
